// File: rtl/vec_add_pkg.sv
// Shared types and default sizing for the vector add engine.
package vec_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    ADD_WRAP = 1'b0,
    ADD_SAT  = 1'b1
  } add_mode_e;

  localparam int VEC_LEN_DEF = 16;
  localparam int ELEM_W_DEF  = 8;
  localparam int LANES_DEF   = 4;

endpackage

// File: rtl/vec_add_lane.sv
// One unsigned element adder with carry-out.
// The saturating path exists only when VEC_ADD_SAT_EN is defined.
module vec_add_lane import vec_add_pkg::*; #(
  parameter int ELEM_W = ELEM_W_DEF
) (
  input  logic [ELEM_W-1:0] a,
  input  logic [ELEM_W-1:0] b,
  input  logic              sat,
  output logic [ELEM_W-1:0] sum,
  output logic              carry
);

  logic [ELEM_W:0] sum_raw;

  assign sum_raw = {1'b0, a} + {1'b0, b};
  assign carry   = sum_raw[ELEM_W];

`ifdef VEC_ADD_SAT_EN
  assign sum = (sat && carry) ? {ELEM_W{1'b1}} : sum_raw[ELEM_W-1:0];
`else
  logic unused_sat;
  assign unused_sat = sat;
  assign sum        = sum_raw[ELEM_W-1:0];
`endif

endmodule

// File: rtl/vec_add_engine.sv
// Multi-cycle element-wise vector adder: LANES elements per beat from a start-time snapshot.
// Optional saturating mode is compiled in with VEC_ADD_SAT_EN.
module vec_add_engine import vec_add_pkg::*; #(
  parameter int VEC_LEN = VEC_LEN_DEF,
  parameter int ELEM_W  = ELEM_W_DEF,
  parameter int LANES   = LANES_DEF
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      start_i,
  input  logic                      mode_i,
  input  logic [VEC_LEN*ELEM_W-1:0] op_a_i,
  input  logic [VEC_LEN*ELEM_W-1:0] op_b_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [VEC_LEN*ELEM_W-1:0] res_o,
  output logic [VEC_LEN-1:0]        res_load_o,
  output logic [VEC_LEN-1:0]        carry_o,
  output logic                      overflow_o
);

  localparam int NBEATS = VEC_LEN / LANES;
  localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

  if (VEC_LEN % LANES != 0) begin : g_cfg_err
    $fatal(1, "vec_add_engine: VEC_LEN must be a multiple of LANES");
  end

  state_e                    state_reg, state_next;
  logic [BEAT_W-1:0]         beat_reg, beat_next;
  logic [VEC_LEN*ELEM_W-1:0] snap_a_reg, snap_b_reg;
  logic [VEC_LEN-1:0]        carry_reg, carry_next;
  logic                      overflow_reg;
  logic                      accept;
  logic                      run;
  logic                      sat_eff;
  logic [LANES*ELEM_W-1:0]   lane_sum;
  logic [LANES-1:0]          lane_carry;
  logic [VEC_LEN-1:0]        elem_hit;

  assign accept = (state_reg == IDLE) && start_i;
  assign run    = (state_reg == RUN);

`ifdef VEC_ADD_SAT_EN
  add_mode_e snap_mode_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      snap_mode_reg <= ADD_WRAP;
    end else if (accept) begin
      snap_mode_reg <= add_mode_e'(mode_i);
    end
  end

  assign sat_eff = (snap_mode_reg == ADD_SAT);
`else
  logic unused_mode;
  assign unused_mode = mode_i;
  assign sat_eff     = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    case (state_reg)
      IDLE: if (start_i) begin
        state_next = RUN;
        beat_next  = '0;
      end
      RUN: if (beat_reg == LAST_BEAT) begin
        state_next = DONE;
        beat_next  = '0;
      end else begin
        beat_next = beat_reg + 1'b1;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg    <= IDLE;
      beat_reg     <= '0;
      snap_a_reg   <= '0;
      snap_b_reg   <= '0;
      carry_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      beat_reg  <= beat_next;
      if (accept) begin
        snap_a_reg   <= op_a_i;
        snap_b_reg   <= op_b_i;
        carry_reg    <= '0;
        overflow_reg <= 1'b0;
      end else begin
        carry_reg    <= carry_next;
        overflow_reg <= overflow_reg | (run & (|lane_carry));
      end
    end
  end

  // Each lane picks its operand pair for the current beat out of the snapshot.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [ELEM_W-1:0] lane_a, lane_b;

    always_comb begin
      lane_a = '0;
      lane_b = '0;
      for (int bt = 0; bt < NBEATS; bt++) begin
        if (beat_reg == BEAT_W'(bt)) begin
          lane_a = snap_a_reg[(bt*LANES+gi)*ELEM_W +: ELEM_W];
          lane_b = snap_b_reg[(bt*LANES+gi)*ELEM_W +: ELEM_W];
        end
      end
    end

    vec_add_lane #(
      .ELEM_W (ELEM_W)
    ) u_lane (
      .a     (lane_a),
      .b     (lane_b),
      .sat   (sat_eff),
      .sum   (lane_sum[gi*ELEM_W +: ELEM_W]),
      .carry (lane_carry[gi])
    );
  end

  for (genvar gi = 0; gi < VEC_LEN; gi++) begin : g_elem
    assign elem_hit[gi]   = run && (beat_reg == BEAT_W'(gi / LANES));
    assign carry_next[gi] = elem_hit[gi] ? lane_carry[gi % LANES] : carry_reg[gi];
    assign res_o[gi*ELEM_W +: ELEM_W] =
      elem_hit[gi] ? lane_sum[(gi % LANES)*ELEM_W +: ELEM_W] : '0;
  end

  assign res_load_o = elem_hit;
  assign busy_o     = run;
  assign done_o     = (state_reg == DONE);
  assign carry_o    = carry_reg;
  assign overflow_o = overflow_reg;

endmodule

// File: tb/tb_vec_add_engine.sv
// Directed self-checking bench for vec_add_engine at default sizing (16 x 8-bit, 4 lanes).
module tb_vec_add_engine;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         mode;
  logic [127:0] op_a;
  logic [127:0] op_b;
  logic         busy;
  logic         done;
  logic [127:0] res;
  logic [15:0]  res_load;
  logic [15:0]  carry;
  logic         overflow;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  vec_add_engine #(
    .VEC_LEN (16),
    .ELEM_W  (8),
    .LANES   (4)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .mode_i     (mode),
    .op_a_i     (op_a),
    .op_b_i     (op_b),
    .busy_o     (busy),
    .done_o     (done),
    .res_o      (res),
    .res_load_o (res_load),
    .carry_o    (carry),
    .overflow_o (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] fill(input logic [7:0] v);
    return {16{v}};
  endfunction

  // Start at the next edge, then check every beat, the done cycle and the idle cycle after.
  task automatic run_op(input string name, input logic [127:0] a, input logic [127:0] b,
                        input logic md, input logic [127:0] exp_res,
                        input logic [15:0] exp_carry, input logic exp_ovf, input bit glitch);
    logic [127:0] mask;
    op_a  = a;
    op_b  = b;
    mode  = md;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (glitch && k == 0) begin
        op_a  = fill(8'h55);
        start = 1'b1;
      end
      if (glitch && k == 1) start = 1'b0;
      mask = {96'b0, 32'hFFFF_FFFF} << (32*k);
      chk({name, " busy"}, busy, 1'b1);
      chk({name, " done_in_run"}, done, 1'b0);
      chk({name, " res_load"}, res_load, 16'h000F << (4*k));
      chk({name, " res"}, res & mask, exp_res & mask);
      @(posedge clk); #1;
    end
    chk({name, " done"}, done, 1'b1);
    chk({name, " busy_in_done"}, busy, 1'b0);
    chk({name, " load_in_done"}, res_load, 16'h0);
    chk({name, " carry"}, carry, exp_carry);
    chk({name, " overflow"}, overflow, exp_ovf);
    @(posedge clk); #1;
    chk({name, " done_cleared"}, done, 1'b0);
    chk({name, " busy_idle"}, busy, 1'b0);
    chk({name, " carry_held"}, carry, exp_carry);
    chk({name, " overflow_held"}, overflow, exp_ovf);
    $display("op %s: carry=%h overflow=%b", name, carry, overflow);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] a_v, b_v, r_v;
    int           cnt0;

    rst_n = 1'b0;
    start = 1'b0;
    mode  = 1'b0;
    op_a  = '0;
    op_b  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst res_load", res_load, 16'h0);
    chk("rst res", res, 128'h0);
    chk("rst carry", carry, 16'h0);
    chk("rst overflow", overflow, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) begin
      a_v[i*8 +: 8] = 8'(i);
      b_v[i*8 +: 8] = 8'(8'h10 + i);
      r_v[i*8 +: 8] = 8'(8'h10 + 2*i);
    end
    run_op("wrap", a_v, b_v, 1'b0, r_v, 16'h0000, 1'b0, 1'b0);

    run_op("carry", fill(8'hFF), fill(8'h01), 1'b0, fill(8'h00), 16'hFFFF, 1'b1, 1'b0);

`ifdef VEC_ADD_SAT_EN
    run_op("sat_hit", fill(8'hF0), fill(8'h20), 1'b1, fill(8'hFF), 16'hFFFF, 1'b1, 1'b0);
`else
    run_op("sat_hit", fill(8'hF0), fill(8'h20), 1'b1, fill(8'h10), 16'hFFFF, 1'b1, 1'b0);
`endif
    run_op("sat_miss", fill(8'h10), fill(8'h20), 1'b1, fill(8'h30), 16'h0000, 1'b0, 1'b0);

    cnt0 = done_cnt;
    run_op("snapshot", fill(8'h01), fill(8'h02), 1'b0, fill(8'h03), 16'h0000, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("snapshot done_pulses", 32'(done_cnt - cnt0), 32'd1);
    chk("snapshot no_requeue", busy, 1'b0);

    // Back-to-back: start held high, accepted at T and T+6.
    op_a  = a_v;
    op_b  = b_v;
    mode  = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    chk("b2b busy_t1", busy, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    chk("b2b done_t5", done, 1'b1);
    chk("b2b busy_t5", busy, 1'b0);
    @(posedge clk); #1;
    chk("b2b busy_t6", busy, 1'b0);
    chk("b2b done_t6", done, 1'b0);
    @(posedge clk); #1;
    chk("b2b busy_t7", busy, 1'b1);
    chk("b2b load_t7", res_load, 16'h000F);
    repeat (4) @(posedge clk);
    #1;
    chk("b2b done_t11", done, 1'b1);
    start = 1'b0;
    @(posedge clk); #1;
    chk("b2b idle_t12", busy, 1'b0);
    $display("op b2b: two accepts with start held high");

    // Reset mid-RUN after an overflowing beat has already been loaded.
    op_a  = fill(8'hFF);
    op_b  = fill(8'h01);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("midrst pre_overflow", overflow, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst busy", busy, 1'b0);
    chk("midrst res_load", res_load, 16'h0);
    chk("midrst done", done, 1'b0);
    chk("midrst overflow", overflow, 1'b0);
    chk("midrst carry", carry, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst idle", busy, 1'b0);
    $display("op midrst: reset during RUN");
    run_op("after_rst", a_v, b_v, 1'b0, r_v, 16'h0000, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
